// File: rtl/fpu_wb_pkg.sv
// Types and constants shared between the FPU top-level and its writeback buffer.
package fpu_wb_pkg;

  // Bit positions inside the 5-bit IEEE status vector {NV,DZ,OF,UF,NX}.
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam int STATUS_W = 5;

  typedef logic [STATUS_W-1:0] fpu_status_t;

  // Tag carried alongside each operation; the FPU top's TagType is this struct.
  typedef struct packed {
    logic [4:0] rd;
    logic       int_dst;
  } fpu_tag_t;

  // Occupancy of the result buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

endpackage

// File: rtl/fpu_result_fifo.sv
// Generic DEPTH-entry pointer FIFO with synchronous flush. Extra pointer MSB
// separates full from empty; storage is reset so the head reads 0 when idle.
module fpu_result_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              wdata,
  output logic [DW-1:0]              rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;

  // Entry storage: written only on an accepted push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // Pointer update; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/fpu_result_buffer.sv
// Result buffer between the FPU and register-file writeback. Queues results in
// order, retires them over valid/ready and accumulates sticky fflags on retire.
module fpu_result_buffer
  import fpu_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   fpu_valid_i,
  output logic                   fpu_ready_o,
  input  logic [WIDTH-1:0]       fpu_result_i,
  input  logic [4:0]             fpu_status_i,
  input  fpu_tag_t               fpu_tag_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [WIDTH-1:0]       wb_data_o,
  output logic [4:0]             wb_rd_o,
  output logic                   wb_int_o,
  output logic [4:0]             fflags_o,
  input  logic                   fflags_wr_i,
  input  logic [4:0]             fflags_wdata_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   busy_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    fpu_status_t      status;
    fpu_tag_t         tag;
  } entry_t;

  entry_t     wentry, head;
  logic       push, pop;
  logic [CW-1:0] cnt_nxt;
  occ_state_t state;

  // Handshake qualifiers: ready/valid are registered, so no wb_ready_i -> fpu_ready_o path.
  assign push = fpu_valid_i & fpu_ready_o & ~flush_i;
  assign pop  = wb_valid_o  & wb_ready_i  & ~flush_i;

  assign wentry = '{result: fpu_result_i, status: fpu_status_i, tag: fpu_tag_i};

  fpu_result_fifo #(
    .DEPTH (DEPTH),
    .DW    ($bits(entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push    (push),
    .pop     (pop),
    .wdata   (wentry),
    .rdata   (head),
    .count   (count_o)
  );

  // Occupancy the FIFO will hold after this edge; flush forces empty.
  always_comb begin
    cnt_nxt = count_o + CW'(push) - CW'(pop);
    if (flush_i) cnt_nxt = '0;
  end

  // Occupancy FSM with registered valid/ready so both track count_o exactly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= OCC_EMPTY;
      wb_valid_o  <= 1'b0;
      fpu_ready_o <= 1'b1;
    end else begin
      if (cnt_nxt == '0) begin
        state       <= OCC_EMPTY;
        wb_valid_o  <= 1'b0;
        fpu_ready_o <= 1'b1;
      end else if (cnt_nxt == CW'(DEPTH)) begin
        state       <= OCC_FULL;
        wb_valid_o  <= 1'b1;
        fpu_ready_o <= 1'b0;
      end else begin
        state       <= OCC_PARTIAL;
        wb_valid_o  <= 1'b1;
        fpu_ready_o <= 1'b1;
      end
    end
  end

  // Sticky flags: CSR write replaces, a retiring result always ORs its flags in.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fflags_o <= '0;
    else         fflags_o <= (fflags_wr_i ? fflags_wdata_i : fflags_o) |
                             (pop ? head.status : 5'b0);
  end

  assign wb_data_o = head.result;
  assign wb_rd_o   = head.tag.rd;
  assign wb_int_o  = head.tag.int_dst;
  assign busy_o    = (state != OCC_EMPTY);

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Bench for fpu_result_buffer: directed stimulus plus a queue scoreboard that
// checks handshake, occupancy, head contents and fflags every cycle.
module tb_fpu_result_buffer;
  import fpu_wb_pkg::*;

  localparam int DEPTH = 2;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             flush_i = 1'b0;
  logic             fpu_valid_i = 1'b0;
  logic             fpu_ready_o;
  logic [WIDTH-1:0] fpu_result_i = '0;
  logic [4:0]       fpu_status_i = '0;
  fpu_tag_t         fpu_tag_i = '0;
  logic             wb_valid_o;
  logic             wb_ready_i = 1'b0;
  logic [WIDTH-1:0] wb_data_o;
  logic [4:0]       wb_rd_o;
  logic             wb_int_o;
  logic [4:0]       fflags_o;
  logic             fflags_wr_i = 1'b0;
  logic [4:0]       fflags_wdata_i = '0;
  logic [$clog2(DEPTH):0] count_o;
  logic             busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [4:0]       rd;
    logic             intd;
    logic [4:0]       st;
  } exp_t;

  exp_t       sb[$];
  logic [4:0] mflags = '0;

  fpu_result_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .fpu_valid_i    (fpu_valid_i),
    .fpu_ready_o    (fpu_ready_o),
    .fpu_result_i   (fpu_result_i),
    .fpu_status_i   (fpu_status_i),
    .fpu_tag_i      (fpu_tag_i),
    .wb_valid_o     (wb_valid_o),
    .wb_ready_i     (wb_ready_i),
    .wb_data_o      (wb_data_o),
    .wb_rd_o        (wb_rd_o),
    .wb_int_o       (wb_int_o),
    .fflags_o       (fflags_o),
    .fflags_wr_i    (fflags_wr_i),
    .fflags_wdata_i (fflags_wdata_i),
    .count_o        (count_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] st,
                       input logic [4:0] rd, input logic intd);
    fpu_valid_i  = v;
    fpu_result_i = res;
    fpu_status_i = st;
    fpu_tag_i    = '{rd: rd, int_dst: intd};
  endtask

  // Scoreboard: check outputs mid-cycle, then advance the model to the next edge.
  always @(negedge clk) begin
    if (!rst_ni) begin
      sb.delete();
      mflags = '0;
    end else begin
      logic do_push, do_pop;
      logic [4:0] st;
      exp_t e;
      chk("count", 64'(count_o), 64'(sb.size()));
      chk("fpu_ready", 64'(fpu_ready_o), 64'(sb.size() != DEPTH));
      chk("wb_valid", 64'(wb_valid_o), 64'(sb.size() != 0));
      chk("busy", 64'(busy_o), 64'(sb.size() != 0));
      chk("fflags", 64'(fflags_o), 64'(mflags));
      if (sb.size() != 0) begin
        chk("wb_data", 64'(wb_data_o), 64'(sb[0].data));
        chk("wb_rd", 64'(wb_rd_o), 64'(sb[0].rd));
        chk("wb_int", 64'(wb_int_o), 64'(sb[0].intd));
      end
      do_push = fpu_valid_i && (sb.size() != DEPTH) && !flush_i;
      do_pop  = wb_ready_i && (sb.size() != 0) && !flush_i;
      st = '0;
      if (do_pop) begin
        st = sb[0].st;
        void'(sb.pop_front());
      end
      if (do_push) begin
        e.data = fpu_result_i; e.rd = fpu_tag_i.rd; e.intd = fpu_tag_i.int_dst; e.st = fpu_status_i;
        sb.push_back(e);
      end
      mflags = (fflags_wr_i ? fflags_wdata_i : mflags) | st;
      if (flush_i) sb.delete();
    end
  end

  initial begin
    // Reset values
    step(); step();
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_ready", 64'(fpu_ready_o), 64'd1);
    chk("rst_fflags", 64'(fflags_o), 64'd0);
    chk("rst_data", 64'(wb_data_o), 64'd0);
    rst_ni = 1'b1;
    step();

    // Single result: one-cycle latency, flags visible after pop
    drive(1'b1, 32'h3F80_0000, 5'b00001, 5'd7, 1'b0);
    step();
    drive(1'b0, '0, '0, '0, 1'b0);
    chk("single_valid", 64'(wb_valid_o), 64'd1);
    chk("single_data", 64'(wb_data_o), 64'h3F80_0000);
    chk("single_rd", 64'(wb_rd_o), 64'd7);
    wb_ready_i = 1'b1;
    step();
    wb_ready_i = 1'b0;
    chk("single_fflags", 64'(fflags_o), 64'd1);

    // Fill under backpressure, third result refused
    drive(1'b1, 32'h0000_000A, 5'b00000, 5'd1, 1'b1);
    step();
    drive(1'b1, 32'h0000_000B, 5'b00000, 5'd2, 1'b0);
    step();
    chk("full_ready", 64'(fpu_ready_o), 64'd0);
    chk("full_count", 64'(count_o), 64'd2);
    drive(1'b1, 32'h0000_000C, 5'b00000, 5'd3, 1'b0);
    step();
    chk("full_hold_count", 64'(count_o), 64'd2);
    chk("full_hold_head", 64'(wb_data_o), 64'h0000_000A);
    drive(1'b0, '0, '0, '0, 1'b0);
    wb_ready_i = 1'b1;
    step();
    chk("drain_ready", 64'(fpu_ready_o), 64'd1);
    chk("drain_head", 64'(wb_data_o), 64'h0000_000B);
    step();
    chk("drain_empty", 64'(wb_valid_o), 64'd0);

    // Wrap-around: back-to-back push+pop
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'(i), 5'b00000, 5'(i), i[0]);
      step();
      chk("wrap_count", 64'(count_o), 64'd1);
      chk("wrap_head", 64'(wb_data_o), 64'(i));
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    step();
    chk("wrap_drained", 64'(count_o), 64'd0);
    wb_ready_i = 1'b0;

    // CSR write concurrent with a retiring result
    fflags_wr_i = 1'b1; fflags_wdata_i = 5'b10000;
    step();
    fflags_wr_i = 1'b0;
    chk("csr_write", 64'(fflags_o), 64'h10);
    drive(1'b1, 32'h0000_0055, 5'b00100, 5'd3, 1'b1);
    step();
    drive(1'b0, '0, '0, '0, 1'b0);
    wb_ready_i = 1'b1; fflags_wr_i = 1'b1; fflags_wdata_i = 5'b00000;
    step();
    wb_ready_i = 1'b0; fflags_wr_i = 1'b0;
    chk("csr_pop_merge", 64'(fflags_o), 64'h04);

    // Flush with two entries held and a concurrent push
    drive(1'b1, 32'h0000_00E0, 5'b11111, 5'd4, 1'b0);
    step();
    drive(1'b1, 32'h0000_00F0, 5'b11111, 5'd5, 1'b0);
    step();
    drive(1'b1, 32'h0000_0990, 5'b11111, 5'd6, 1'b0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_valid", 64'(wb_valid_o), 64'd0);
    chk("flush_fflags", 64'(fflags_o), 64'h04);
    wb_ready_i = 1'b1;
    step(); step();
    chk("flush_no_ghost", 64'(wb_valid_o), 64'd0);
    wb_ready_i = 1'b0;

    // Asynchronous reset mid-traffic
    drive(1'b1, 32'h1234_5678, 5'b00010, 5'd8, 1'b0);
    step();
    drive(1'b1, 32'h9ABC_DEF0, 5'b00010, 5'd9, 1'b1);
    step();
    drive(1'b0, '0, '0, '0, 1'b0);
    chk("pre_rst_count", 64'(count_o), 64'd2);
    rst_ni = 1'b0;
    #1;
    chk("arst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("arst_count", 64'(count_o), 64'd0);
    chk("arst_fflags", 64'(fflags_o), 64'd0);
    chk("arst_ready", 64'(fpu_ready_o), 64'd1);
    chk("arst_data", 64'(wb_data_o), 64'd0);
    step();
    rst_ni = 1'b1;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpu_result_buffer.md
# fpu_result_buffer

- Sits directly downstream of the FPU top-level, between its result handshake and the core's register-file writeback port.
- Holds completed FPU results in a small FIFO and presents them in order to writeback with a valid/ready handshake.
- Accumulates the sticky IEEE exception flags (fflags) at retire time.
- Gives the CSR unit a write path to fflags and gives the pipeline flush and occupancy visibility.

## Interface
Parameters:
- DEPTH, 2, FIFO entries; power of two, ≥2.
- WIDTH, 32, result data width.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- flush_i  in  1  synchronous flush; discards all buffered entries.
- fpu_valid_i  in  1  FPU result valid.
- fpu_ready_o  out  1  buffer can accept a result.
- fpu_result_i  in  WIDTH  FPU result.
- fpu_status_i  in  5  {NV,DZ,OF,UF,NX} flags of this result.
- fpu_tag_i  in  fpu_tag_t (6)  {rd[4:0], int_dst}.
- wb_valid_o  out  1  head entry valid.
- wb_ready_i  in  1  writeback accepts head.
- wb_data_o  out  WIDTH  head result.
- wb_rd_o  out  5  head destination register.
- wb_int_o  out  1  1 = integer RF (compare/class/cvt-to-int), 0 = FP RF.
- fflags_o  out  5  accumulated sticky flags.
- fflags_wr_i  in  1  CSR write strobe.
- fflags_wdata_i  in  5  CSR write value.
- count_o  out  $clog2(DEPTH)+1  occupied entries.
- busy_o  out  1  count_o != 0.

## Operation
- Push = fpu_valid_i & fpu_ready_o & !flush_i.
  - Writes {result, status, tag} at wr_ptr.
  - wr_ptr increments.
- Pop = wb_valid_o & wb_ready_i & !flush_i.
  - rd_ptr increments.
- Pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty on wrap-around.
  - count_o = wr_ptr − rd_ptr (modulo).
- fpu_ready_o = (count_o != DEPTH).
  - No same-cycle pass-through when full: a pop in a full cycle frees the slot only for the next cycle.
- Push and pop in the same cycle: both occur and count_o is unchanged. Legal at any count below DEPTH.
- wb_valid_o = (count_o != 0). Head fields come combinationally from the rd_ptr entry.
- wb_valid_o, once asserted, holds with stable data until popped or flushed.
- fflags update rule:
  - fflags_next = (fflags_wr_i ? fflags_wdata_i : fflags_o) | (pop ? head.status : 5'b0).
  - A popped result's flags are never lost to a simultaneous CSR write.
- Flush:
  - Resets both pointers to 0 at the next edge.
  - Any push or pop in the flush cycle is suppressed.
  - fflags are not affected by flush, but a fflags_wr_i in the flush cycle still applies.
- Occupancy states: EMPTY → PARTIAL → FULL.
  - Transitions follow net push − pop.
  - Flush returns to EMPTY from any state.

## Timing
- Reset values:
  - wb_valid_o = 0, count_o = 0, busy_o = 0, fflags_o = 0.
  - wb_data_o / wb_rd_o / wb_int_o = 0, because storage is reset.
  - fpu_ready_o = 1.
- Latency: a result pushed at edge N shows wb_valid_o = 1 after edge N (cycle N+1). Minimum one cycle, no bypass.
- fflags_o reflects a pop or CSR write one cycle after the edge that performs it.
- Throughput: one push and one pop per cycle in steady state.
- Reset asserted mid-operation immediately clears all state and outputs (asynchronous). Buffered entries and flags are lost.
- All outputs derive from registers plus head-mux logic only. No combinational path from wb_ready_i to fpu_ready_o.

## Structure
- Shared package fpu_wb_pkg:
  - fpu_tag_t packed struct {logic [4:0] rd; logic int_dst;}. The FPU top's TagType is set to it.
  - status flag bit-index constants NV=4, DZ=3, OF=2, UF=1, NX=0.
  - buffer entry struct {result, status, tag}.
- One natural sub-module: fpu_result_fifo, a generic DEPTH-entry pointer FIFO with flush.
  - fflags accumulation and tag unpacking stay in the top.

## Test plan
- Reset: rst_ni low mid-traffic with 2 entries held.
  - Immediately: wb_valid_o = 0, count_o = 0, fflags_o = 0, fpu_ready_o = 1.
- Single result: push result 0x3F800000, status 5'b00001, tag {rd=7, int=0}.
  - Next cycle: wb_valid_o = 1, wb_data_o = 0x3F800000, wb_rd_o = 7.
  - Pop.
  - Following cycle: fflags_o = 5'b00001.
- Full with backpressure: wb_ready_i = 0, push 2 results.
  - fpu_ready_o = 0, count_o = 2.
  - Third fpu_valid_i is not accepted.
  - Release wb_ready_i: results drain in order A, B. fpu_ready_o returns 1 one cycle after the first pop.
- Wrap-around: 10 back-to-back push+pop cycles with ascending data 1..10.
  - Writeback sees 1..10 in order.
  - count_o stays 1 after the first push.
- Simultaneous CSR write and pop: fflags_o = 5'b10000, fflags_wr_i = 1 with wdata 5'b00000, popped status 5'b00100.
  - Result: fflags_o = 5'b00100.
- Flush with 2 entries plus concurrent push.
  - Next cycle: count_o = 0, wb_valid_o = 0.
  - The pushed entry never appears.
  - fflags_o unchanged.
